mitm_burst_logic: RTL and testbench
===================================

MITM_BURST_LOGIC -- requirements
Module: mitm_burst_logic

Interface
REQ-001 Parameter BUF_SIZE, default 16: width of bus-control data buffers.
REQ-002 Parameter CHUNK_SIZE_WIDTH, default $clog2(BUF_SIZE+1): width of next_chunk_size.
REQ-003 Parameter INSTR_BITS, default 3: start bit plus opcode bits.
REQ-004 Parameter READ_OPCODE, default 3'b110: value identifying a read.
REQ-005 Parameter ADDR_BITS, default 9: address operand width.
REQ-006 Parameter DATA_BITS, default 8: data word width; DATA_BITS, ADDR_BITS and INSTR_BITS are each <= BUF_SIZE.
REQ-007 Parameter FAKE_DATA, default 8'h24: substituted word value.
REQ-008 Parameter MAX_WORDS, default 16: maximum data words handled per transaction.
REQ-009 Parameters MODE_WIDTH=3, MODE_FORWARD=0, MODE_SUB_ALL=1, MODE_SUB_HALF=2, MODE_SUB_RANGE=3.
REQ-010 sys_clk  in  1  system clock; all logic on its rising edge.
REQ-011 rst  in  1  reset, asynchronous, active-high.
REQ-012 mode_select  in  MODE_WIDTH  requested MITM mode.
REQ-013 range_lo, range_hi  in  ADDR_BITS each  inclusive substitution address window.
REQ-014 comm_active  in  1  bus transaction in progress.
REQ-015 bus_ready  in  1  current chunk transferred; real_*_data valid.
REQ-016 real_miso_data, real_mosi_data  in  BUF_SIZE each  captured chunk, LSB-aligned.
REQ-017 cmd_next_chunk, cmd_finish  out  1 each  single-cycle commands to bus control.
REQ-018 next_chunk_size  out  CHUNK_SIZE_WIDTH  bits in next chunk.
REQ-019 fake_miso_select, fake_mosi_select  out  1 each  substitute the line when high.
REQ-020 fake_miso_data, fake_mosi_data  out  BUF_SIZE each  substitute data, MSB-aligned.
REQ-021 sub_count  out  8  substituted words since reset, saturating at 255.

Function
REQ-022 States: IDLE, INSTR_START, INSTR, ADDR_START, ADDR, DATA_START, DATA, FINISH_START, FINISH.
REQ-023 IDLE with comm_active=1: next_chunk_size=INSTR_BITS, both selects=0, cmd_next_chunk=1, go to INSTR_START.
REQ-024 Each *_START state: deassert cmd_next_chunk and cmd_finish, advance to its wait state; commands are exactly one cycle wide.
REQ-025 INSTR with bus_ready: real_mosi_data[INSTR_BITS-1:0]==READ_OPCODE -> next_chunk_size=ADDR_BITS, cmd_next_chunk, ADDR_START; else next_chunk_size=0, cmd_finish, FINISH_START.
REQ-026 ADDR with bus_ready: latch mode_select into mode_q and real_mosi_data[ADDR_BITS-1:0] into addr_q; word counter cleared.
REQ-027 mode_q FORWARD or undefined encoding: next_chunk_size=0, cmd_finish, FINISH_START.
REQ-028 Otherwise: next_chunk_size=DATA_BITS, fake_miso_data=FAKE_DATA<<(BUF_SIZE-DATA_BITS), fake_miso_select=subst(addr), cmd_next_chunk, DATA_START.
REQ-029 subst(a): SUB_ALL -> 1; SUB_HALF -> a[0]; SUB_RANGE -> range_lo<=a<=range_hi (unsigned, empty window if lo>hi); else 0.
REQ-030 DATA with bus_ready: if fake_miso_select=1, sub_count increments unless at 255; word counter increments.
REQ-031 Same event: counter reaching MAX_WORDS -> cmd_finish, fake_miso_select=0, FINISH_START; else addr_q<=addr_q+1 mod 2^ADDR_BITS, fake_miso_select=subst(addr_q+1), cmd_next_chunk, DATA_START.
REQ-032 mode_q and range inputs sampled per word; mode_select changes mid-transaction have no effect.
REQ-033 INSTR, ADDR, DATA with bus_ready=0 and comm_active=0: go to FINISH without commands; bus_ready takes priority when both occur.
REQ-034 FINISH with comm_active=0: next_chunk_size=0, both selects=0, go to IDLE.
REQ-035 fake_mosi_select held 0 and fake_mosi_data held 0 in all states.
REQ-036 Word-to-decision latency: select for word n+1 valid one cycle after bus_ready for word n.

Reset
REQ-037 rst=1 immediately forces state=IDLE, all outputs 0, sub_count=0, addr_q=0, mode_q=0, word counter=0, regardless of clock.
REQ-038 Reset mid-transaction abandons it; after rst release, block waits in IDLE and re-arms on comm_active=1 (including one already high).

Verification
REQ-039 Read opcode, addr 0x005, MODE_SUB_HALF, 3 words -> selects 1,0,1 (addr 5,6,7); sub_count=2; fake_miso_data=0x2400.
REQ-040 Opcode 3'b101 -> cmd_finish one cycle after instruction bus_ready; no address chunk; selects stay 0.
REQ-041 MODE_SUB_RANGE, lo=0x1FE, hi=0x001, addr 0x1FF, 4 words -> empty window, all selects 0; addr wraps 0x1FF->0x000 without error.
REQ-042 MODE_SUB_ALL, 16 bus_ready words with comm_active held -> cmd_finish after 16th word; sub_count=16; no 17th cmd_next_chunk.
REQ-043 comm_active drops in DATA before bus_ready -> FINISH then IDLE, selects 0, sub_count unchanged.
REQ-044 rst pulse between clock edges during DATA -> outputs 0 before next edge; new transaction then runs normally.

Source files
------------

// File: rtl/mitm_burst_logic.sv
// Man-in-the-middle controller for a chunked serial bus: decodes instruction and address chunks,
// then decides word by word whether the MISO line is replaced with a fixed fake value.
module mitm_burst_logic #(
    parameter int                    BUF_SIZE         = 16,
    parameter int                    CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
    parameter int                    INSTR_BITS       = 3,
    parameter logic [INSTR_BITS-1:0] READ_OPCODE      = 3'b110,
    parameter int                    ADDR_BITS        = 9,
    parameter int                    DATA_BITS        = 8,
    parameter logic [DATA_BITS-1:0]  FAKE_DATA        = 8'h24,
    parameter int                    MAX_WORDS        = 16,
    parameter int                    MODE_WIDTH       = 3,
    parameter int                    MODE_FORWARD     = 0,
    parameter int                    MODE_SUB_ALL     = 1,
    parameter int                    MODE_SUB_HALF    = 2,
    parameter int                    MODE_SUB_RANGE   = 3
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic [MODE_WIDTH-1:0]       mode_select,
    input  logic [ADDR_BITS-1:0]        range_lo,
    input  logic [ADDR_BITS-1:0]        range_hi,
    input  logic                        comm_active,
    input  logic                        bus_ready,
    input  logic [BUF_SIZE-1:0]         real_miso_data,
    input  logic [BUF_SIZE-1:0]         real_mosi_data,
    output logic                        cmd_next_chunk,
    output logic                        cmd_finish,
    output logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
    output logic                        fake_miso_select,
    output logic                        fake_mosi_select,
    output logic [BUF_SIZE-1:0]         fake_miso_data,
    output logic [BUF_SIZE-1:0]         fake_mosi_data,
    output logic [7:0]                  sub_count
);

    localparam int WCNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [MODE_WIDTH-1:0] M_FWD   = MODE_WIDTH'(MODE_FORWARD);
    localparam logic [MODE_WIDTH-1:0] M_ALL   = MODE_WIDTH'(MODE_SUB_ALL);
    localparam logic [MODE_WIDTH-1:0] M_HALF  = MODE_WIDTH'(MODE_SUB_HALF);
    localparam logic [MODE_WIDTH-1:0] M_RANGE = MODE_WIDTH'(MODE_SUB_RANGE);
    // Fake word is sent MSB-first, so it sits at the top of the buffer.
    localparam logic [BUF_SIZE-1:0] FAKE_ALIGNED = BUF_SIZE'(FAKE_DATA) << (BUF_SIZE - DATA_BITS);

    typedef enum logic [3:0] {
        IDLE, INSTR_START, INSTR, ADDR_START, ADDR, DATA_START, DATA, FINISH_START, FINISH
    } state_t;

    state_t                      state_q, state_d;
    logic                        cmdNext_q, cmdNext_d;
    logic                        cmdFinish_q, cmdFinish_d;
    logic [CHUNK_SIZE_WIDTH-1:0] chunkSize_q, chunkSize_d;
    logic                        fakeSel_q, fakeSel_d;
    logic [BUF_SIZE-1:0]         fakeData_q, fakeData_d;
    logic [7:0]                  subCnt_q, subCnt_d;
    logic [ADDR_BITS-1:0]        addr_q, addr_d;
    logic [MODE_WIDTH-1:0]       mode_q, mode_d;
    logic [WCNT_W-1:0]           wordCnt_q, wordCnt_d;
    logic [WCNT_W-1:0]           wordCntInc;
    logic [ADDR_BITS-1:0]        addrIn;
    logic [ADDR_BITS-1:0]        addrInc;
    logic                        unused_inputs;

    function automatic logic validMode(input logic [MODE_WIDTH-1:0] m);
        logic ok;
        ok = 1'b0;
        case (m)
            M_FWD:                  ok = 1'b0;
            M_ALL, M_HALF, M_RANGE: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic subst(input logic [MODE_WIDTH-1:0] m, input logic [ADDR_BITS-1:0] a,
                                   input logic [ADDR_BITS-1:0] lo, input logic [ADDR_BITS-1:0] hi);
        logic hit;
        hit = 1'b0;
        case (m)
            M_ALL:   hit = 1'b1;
            M_HALF:  hit = a[0];
            M_RANGE: hit = (a >= lo) && (a <= hi);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign addrIn        = real_mosi_data[ADDR_BITS-1:0];
    assign addrInc       = addr_q + ADDR_BITS'(1);
    assign wordCntInc    = wordCnt_q + WCNT_W'(1);
    assign unused_inputs = ^{real_miso_data, real_mosi_data};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmdNext_q   <= 1'b0;
            cmdFinish_q <= 1'b0;
            chunkSize_q <= '0;
            fakeSel_q   <= 1'b0;
            fakeData_q  <= '0;
            subCnt_q    <= '0;
            addr_q      <= '0;
            mode_q      <= '0;
            wordCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmdNext_q   <= cmdNext_d;
            cmdFinish_q <= cmdFinish_d;
            chunkSize_q <= chunkSize_d;
            fakeSel_q   <= fakeSel_d;
            fakeData_q  <= fakeData_d;
            subCnt_q    <= subCnt_d;
            addr_q      <= addr_d;
            mode_q      <= mode_d;
            wordCnt_q   <= wordCnt_d;
        end
    end

    // Commands default low so every pulse lasts exactly one cycle; other outputs hold.
    always_comb begin
        state_d     = state_q;
        cmdNext_d   = 1'b0;
        cmdFinish_d = 1'b0;
        chunkSize_d = chunkSize_q;
        fakeSel_d   = fakeSel_q;
        fakeData_d  = fakeData_q;
        subCnt_d    = subCnt_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        wordCnt_d   = wordCnt_q;
        case (state_q)
            IDLE: begin
                if (comm_active) begin
                    chunkSize_d = CHUNK_SIZE_WIDTH'(INSTR_BITS);
                    fakeSel_d   = 1'b0;
                    cmdNext_d   = 1'b1;
                    state_d     = INSTR_START;
                end
            end
            INSTR_START:  state_d = INSTR;
            ADDR_START:   state_d = ADDR;
            DATA_START:   state_d = DATA;
            FINISH_START: state_d = FINISH;
            INSTR: begin
                if (bus_ready) begin
                    if (real_mosi_data[INSTR_BITS-1:0] == READ_OPCODE) begin
                        chunkSize_d = CHUNK_SIZE_WIDTH'(ADDR_BITS);
                        cmdNext_d   = 1'b1;
                        state_d     = ADDR_START;
                    end else begin
                        chunkSize_d = '0;
                        cmdFinish_d = 1'b1;
                        state_d     = FINISH_START;
                    end
                end else if (!comm_active) begin
                    state_d = FINISH;
                end
            end
            ADDR: begin
                if (bus_ready) begin
                    mode_d    = mode_select;
                    addr_d    = addrIn;
                    wordCnt_d = '0;
                    if (validMode(mode_select)) begin
                        chunkSize_d = CHUNK_SIZE_WIDTH'(DATA_BITS);
                        fakeData_d  = FAKE_ALIGNED;
                        fakeSel_d   = subst(mode_select, addrIn, range_lo, range_hi);
                        cmdNext_d   = 1'b1;
                        state_d     = DATA_START;
                    end else begin
                        chunkSize_d = '0;
                        cmdFinish_d = 1'b1;
                        state_d     = FINISH_START;
                    end
                end else if (!comm_active) begin
                    state_d = FINISH;
                end
            end
            DATA: begin
                if (bus_ready) begin
                    if (fakeSel_q && (subCnt_q != 8'hFF)) begin
                        subCnt_d = subCnt_q + 8'd1;
                    end
                    wordCnt_d = wordCntInc;
                    if (wordCntInc == WCNT_W'(MAX_WORDS)) begin
                        cmdFinish_d = 1'b1;
                        fakeSel_d   = 1'b0;
                        state_d     = FINISH_START;
                    end else begin
                        addr_d    = addrInc;
                        fakeSel_d = subst(mode_q, addrInc, range_lo, range_hi);
                        cmdNext_d = 1'b1;
                        state_d   = DATA_START;
                    end
                end else if (!comm_active) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (!comm_active) begin
                    chunkSize_d = '0;
                    fakeSel_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_next_chunk   = cmdNext_q;
    assign cmd_finish       = cmdFinish_q;
    assign next_chunk_size  = chunkSize_q;
    assign fake_miso_select = fakeSel_q;
    assign fake_miso_data   = fakeData_q;
    assign fake_mosi_select = 1'b0;
    assign fake_mosi_data   = '0;
    assign sub_count        = subCnt_q;

endmodule

// File: tb/tb_mitm_burst_logic.sv
// Directed bench for mitm_burst_logic: each scenario drives chunks by hand and compares
// outputs against values worked out from the address/mode rules.
module tb_mitm_burst_logic;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [2:0]  mode_select;
    logic [8:0]  range_lo, range_hi;
    logic        comm_active, bus_ready;
    logic [15:0] real_miso_data, real_mosi_data;
    logic        cmd_next_chunk, cmd_finish;
    logic [4:0]  next_chunk_size;
    logic        fake_miso_select, fake_mosi_select;
    logic [15:0] fake_miso_data, fake_mosi_data;
    logic [7:0]  sub_count;

    int assertCount = 0;
    int failCount   = 0;

    mitm_burst_logic dut (
        .sys_clk(sys_clk), .rst(rst), .mode_select(mode_select),
        .range_lo(range_lo), .range_hi(range_hi), .comm_active(comm_active),
        .bus_ready(bus_ready), .real_miso_data(real_miso_data), .real_mosi_data(real_mosi_data),
        .cmd_next_chunk(cmd_next_chunk), .cmd_finish(cmd_finish), .next_chunk_size(next_chunk_size),
        .fake_miso_select(fake_miso_select), .fake_mosi_select(fake_mosi_select),
        .fake_miso_data(fake_miso_data), .fake_mosi_data(fake_mosi_data), .sub_count(sub_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One bus_ready pulse carrying a chunk; the decision is visible on return.
    task automatic applyStimulus(input logic [15:0] mosi);
        real_mosi_data = mosi;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
    endtask

    task automatic startTxn(input logic [2:0] mode, input logic [15:0] addr);
        comm_active = 1'b1;
        tick();
        tick();
        applyStimulus(16'h0006);
        tick();
        mode_select = mode;
        applyStimulus(addr);
    endtask

    task automatic endTxn();
        comm_active = 1'b0;
        repeat (4) tick();
    endtask

    logic expSel[4];

    initial begin
        rst = 1'b0; comm_active = 1'b0; bus_ready = 1'b0; mode_select = '0;
        range_lo = '0; range_hi = '0; real_miso_data = '0; real_mosi_data = '0;
        #2 rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_cmd_next", 32'(cmd_next_chunk), 0);
        checkOutput("rst_cmd_finish", 32'(cmd_finish), 0);
        checkOutput("rst_size", 32'(next_chunk_size), 0);
        checkOutput("rst_miso_sel", 32'(fake_miso_select), 0);
        checkOutput("rst_miso_data", 32'(fake_miso_data), 0);
        checkOutput("rst_sub_count", 32'(sub_count), 0);
        rst = 1'b0;
        tick();

        // SUB_HALF read from 0x005, three words; mode_select changed mid-burst must be ignored.
        comm_active = 1'b1;
        tick();
        checkOutput("half_instr_cmd", 32'(cmd_next_chunk), 1);
        checkOutput("half_instr_size", 32'(next_chunk_size), 3);
        tick();
        checkOutput("half_cmd_one_cycle", 32'(cmd_next_chunk), 0);
        applyStimulus(16'h0006);
        checkOutput("half_addr_size", 32'(next_chunk_size), 9);
        checkOutput("half_addr_cmd", 32'(cmd_next_chunk), 1);
        tick();
        mode_select = 3'd2;
        applyStimulus(16'h0005);
        checkOutput("half_sel_a5", 32'(fake_miso_select), 1);
        checkOutput("half_fake_data", 32'(fake_miso_data), 32'h2400);
        checkOutput("half_data_size", 32'(next_chunk_size), 8);
        tick();
        mode_select = 3'd0;
        applyStimulus(16'h0000);
        checkOutput("half_sel_a6", 32'(fake_miso_select), 0);
        checkOutput("half_sub_w1", 32'(sub_count), 1);
        tick();
        applyStimulus(16'h0000);
        checkOutput("half_sel_a7", 32'(fake_miso_select), 1);
        tick();
        applyStimulus(16'h0000);
        checkOutput("half_sub_final", 32'(sub_count), 2);
        endTxn();
        checkOutput("half_idle_sel", 32'(fake_miso_select), 0);
        checkOutput("half_idle_size", 32'(next_chunk_size), 0);
        checkOutput("mosi_sel_zero", 32'(fake_mosi_select), 0);
        checkOutput("mosi_data_zero", 32'(fake_mosi_data), 0);

        // Non-read opcode finishes right after the instruction chunk.
        comm_active = 1'b1;
        tick();
        tick();
        applyStimulus(16'h0005);
        checkOutput("nonread_finish", 32'(cmd_finish), 1);
        checkOutput("nonread_no_next", 32'(cmd_next_chunk), 0);
        checkOutput("nonread_size", 32'(next_chunk_size), 0);
        tick();
        checkOutput("nonread_finish_pulse", 32'(cmd_finish), 0);
        checkOutput("nonread_sel", 32'(fake_miso_select), 0);
        endTxn();

        // Inverted range is empty; address wraps from 0x1FF to 0x000.
        range_lo = 9'h1FE; range_hi = 9'h001;
        startTxn(3'd3, 16'h01FF);
        checkOutput("empty_sel_first", 32'(fake_miso_select), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            applyStimulus(16'h0000);
            checkOutput($sformatf("empty_sel_w%0d", i), 32'(fake_miso_select), 0);
        end
        endTxn();
        checkOutput("empty_sub", 32'(sub_count), 2);

        // Window 0x000..0x001 reached across the wrap from 0x1FE.
        range_lo = 9'h000; range_hi = 9'h001;
        expSel[0] = 1'b0; expSel[1] = 1'b1; expSel[2] = 1'b1; expSel[3] = 1'b0;
        startTxn(3'd3, 16'h01FE);
        checkOutput("range_sel_first", 32'(fake_miso_select), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            applyStimulus(16'h0000);
            checkOutput($sformatf("range_sel_w%0d", i), 32'(fake_miso_select), 32'(expSel[i]));
        end
        endTxn();
        checkOutput("range_sub", 32'(sub_count), 4);

        // SUB_ALL burst stops after MAX_WORDS words.
        startTxn(3'd1, 16'h00F0);
        for (int i = 0; i < 16; i++) begin
            tick();
            applyStimulus(16'h0000);
            if (i < 15) begin
                checkOutput($sformatf("all_next_w%0d", i), 32'(cmd_next_chunk), 1);
            end
        end
        checkOutput("all_finish", 32'(cmd_finish), 1);
        checkOutput("all_no_17th", 32'(cmd_next_chunk), 0);
        checkOutput("all_sel_off", 32'(fake_miso_select), 0);
        checkOutput("all_sub", 32'(sub_count), 20);
        tick();
        applyStimulus(16'h0000);
        checkOutput("all_finish_hold", 32'(cmd_next_chunk), 0);
        endTxn();

        // comm_active drops while waiting for a data word.
        startTxn(3'd1, 16'h0000);
        checkOutput("drop_sel_before", 32'(fake_miso_select), 1);
        tick();
        comm_active = 1'b0;
        tick();
        checkOutput("drop_no_cmd", 32'(cmd_finish | cmd_next_chunk), 0);
        tick();
        checkOutput("drop_sel_idle", 32'(fake_miso_select), 0);
        checkOutput("drop_sub", 32'(sub_count), 20);

        // Asynchronous reset between edges in DATA, then re-arm with comm_active still high.
        startTxn(3'd1, 16'h0010);
        tick();
        applyStimulus(16'h0000);
        checkOutput("arst_sub_before", 32'(sub_count), 21);
        tick();
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_sel", 32'(fake_miso_select), 0);
        checkOutput("arst_sub", 32'(sub_count), 0);
        checkOutput("arst_size", 32'(next_chunk_size), 0);
        checkOutput("arst_data", 32'(fake_miso_data), 0);
        #1 rst = 1'b0;
        tick();
        checkOutput("rearm_cmd", 32'(cmd_next_chunk), 1);
        tick();
        applyStimulus(16'h0006);
        tick();
        mode_select = 3'd2;
        applyStimulus(16'h0002);
        checkOutput("rearm_sel_a2", 32'(fake_miso_select), 0);
        tick();
        applyStimulus(16'h0000);
        checkOutput("rearm_sel_a3", 32'(fake_miso_select), 1);
        tick();
        applyStimulus(16'h0000);
        endTxn();
        checkOutput("rearm_sub", 32'(sub_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
